// File: rtl/physics_pkg.sv
// Shared types, playfield defaults and saturating arithmetic helpers for the
// physics step engine and its wall clamp.
package physics_pkg;

    localparam int COORD_W    = 16;
    localparam int X_MAX_DEF  = 639;
    localparam int Y_MAX_DEF  = 479;
    localparam int BALL_R_DEF = 8;
    localparam int V_LIM_DEF  = 64;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        INTEG,
        COLLIDE,
        OUTPUT
    } phys_state_t;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [COORD_W:0]   wide_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
        coord_t vx;
        coord_t vy;
    } ball_state_t;

    localparam wide_t COORD_MIN = wide_t'(-(2 ** (COORD_W - 1)));
    localparam wide_t COORD_MAX = wide_t'((2 ** (COORD_W - 1)) - 1);

    // One guard bit is enough to see any overflow of a COORD_W + COORD_W add.
    function automatic coord_t sat_add(input coord_t a, input coord_t b,
                                       input wide_t lo, input wide_t hi);
        wide_t  w_sum;
        coord_t w_res;
        w_sum = wide_t'(a) + wide_t'(b);
        if (w_sum < lo)
            w_res = coord_t'(lo);
        else if (w_sum > hi)
            w_res = coord_t'(hi);
        else
            w_res = coord_t'(w_sum);
        return w_res;
    endfunction

    function automatic coord_t neg_sat(input coord_t v);
        coord_t w_res;
        if (v == coord_t'(COORD_MIN))
            w_res = coord_t'(COORD_MAX);
        else
            w_res = -v;
        return w_res;
    endfunction

endpackage

// File: rtl/phys_wall_clamp.sv
// Single-axis wall test: pins the centre inside [RADIUS, MAX_POS-RADIUS]
// and reflects the velocity whenever either wall is touched.
module phys_wall_clamp
    import physics_pkg::*;
#(
    parameter int MAX_POS = X_MAX_DEF,
    parameter int RADIUS  = BALL_R_DEF
)(
    input  coord_t i_pos,
    input  coord_t i_vel,
    output coord_t o_pos,
    output coord_t o_vel,
    output logic   o_hit
);

    localparam coord_t LO = coord_t'(RADIUS);
    localparam coord_t HI = coord_t'(MAX_POS - RADIUS);

    always_comb begin
        o_pos = i_pos;
        o_vel = i_vel;
        o_hit = 1'b0;
        if (i_pos < LO) begin
            o_pos = LO;
            o_vel = neg_sat(i_vel);
            o_hit = 1'b1;
        end else if (i_pos > HI) begin
            o_pos = HI;
            o_vel = neg_sat(i_vel);
            o_hit = 1'b1;
        end
    end

endmodule

// File: rtl/physics_step_engine.sv
// Per-frame Euler integrator for one ball: integrate, clamp against the walls,
// then hand the new state to the render stage over valid/ready.
module physics_step_engine
    import physics_pkg::*;
#(
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF,
    parameter int BALL_R = BALL_R_DEF,
    parameter int V_LIM  = V_LIM_DEF
)(
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 ctrl_enable,
    input  logic                 ctrl_load,
    input  logic [COORD_W-1:0]   gravity,
    input  logic [2*COORD_W-1:0] init_pos,
    input  logic [2*COORD_W-1:0] init_vel,
    input  logic                 frame_tick,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*COORD_W-1:0] out_pos,
    output logic [2*COORD_W-1:0] out_vel,
    output logic [15:0]          bounce_count,
    output logic [7:0]           overrun_count,
    output logic                 busy
);

    localparam wide_t V_HI = wide_t'(V_LIM);
    localparam wide_t V_LO = wide_t'(-V_LIM);

    phys_state_t          r_state;
    phys_state_t          w_next;
    ball_state_t          r_ball;
    logic                 r_pend_valid;
    logic [2*COORD_W-1:0] r_pend_pos;
    logic [2*COORD_W-1:0] r_pend_vel;
    logic [15:0]          r_bounce;
    logic [7:0]           r_overrun;

    logic                 w_accept;
    logic                 w_apply_load;
    logic                 w_tick_en;
    logic                 w_busy;
    logic [2*COORD_W-1:0] w_load_pos;
    logic [2*COORD_W-1:0] w_load_vel;
    coord_t               w_cx, w_cvx, w_cy, w_cvy;
    logic                 w_hit_x, w_hit_y;

    // A load seen in OUTPUT waits for the handshake so out_valid never drops unaccepted.
    assign w_accept     = (r_state == OUTPUT) && out_ready;
    assign w_apply_load = ((r_state != OUTPUT) && ctrl_load)
                       || (w_accept && (ctrl_load || r_pend_valid));
    assign w_load_pos   = ctrl_load ? init_pos : r_pend_pos;
    assign w_load_vel   = ctrl_load ? init_vel : r_pend_vel;
    assign w_tick_en    = frame_tick && ctrl_enable;

    phys_wall_clamp #(.MAX_POS(X_MAX), .RADIUS(BALL_R)) u_clamp_x (
        .i_pos (r_ball.x),
        .i_vel (r_ball.vx),
        .o_pos (w_cx),
        .o_vel (w_cvx),
        .o_hit (w_hit_x)
    );

    phys_wall_clamp #(.MAX_POS(Y_MAX), .RADIUS(BALL_R)) u_clamp_y (
        .i_pos (r_ball.y),
        .i_vel (r_ball.vy),
        .o_pos (w_cy),
        .o_vel (w_cvy),
        .o_hit (w_hit_y)
    );

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        w_busy    = 1'b0;
        if (w_apply_load) begin
            w_next = WAIT_TICK;
        end else begin
            case (r_state)
                WAIT_TICK: if (w_tick_en) w_next = INTEG;
                INTEG:     w_next = COLLIDE;
                COLLIDE:   w_next = OUTPUT;
                OUTPUT:    if (w_accept) w_next = WAIT_TICK;
                default:   w_next = r_state;
            endcase
        end
        case (r_state)
            INTEG, COLLIDE: w_busy = 1'b1;
            OUTPUT: begin
                w_busy    = 1'b1;
                out_valid = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            r_ball       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_pos   <= '0;
            r_pend_vel   <= '0;
            r_bounce     <= '0;
            r_overrun    <= '0;
        end else if (w_apply_load) begin
            r_ball.x     <= coord_t'(w_load_pos[COORD_W-1:0]);
            r_ball.y     <= coord_t'(w_load_pos[2*COORD_W-1:COORD_W]);
            r_ball.vx    <= coord_t'(w_load_vel[COORD_W-1:0]);
            r_ball.vy    <= coord_t'(w_load_vel[2*COORD_W-1:COORD_W]);
            r_pend_valid <= 1'b0;
            r_bounce     <= '0;
            r_overrun    <= '0;
        end else begin
            case (r_state)
                INTEG: begin
                    r_ball.x  <= sat_add(r_ball.x, r_ball.vx, COORD_MIN, COORD_MAX);
                    r_ball.y  <= sat_add(r_ball.y, r_ball.vy, COORD_MIN, COORD_MAX);
                    r_ball.vy <= sat_add(r_ball.vy, coord_t'(gravity), V_LO, V_HI);
                end
                COLLIDE: begin
                    r_ball.x  <= w_cx;
                    r_ball.vx <= w_cvx;
                    r_ball.y  <= w_cy;
                    r_ball.vy <= w_cvy;
                    r_bounce  <= r_bounce + 16'(w_hit_x) + 16'(w_hit_y);
                end
                default: ;
            endcase
            if (w_busy && w_tick_en && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
            if ((r_state == OUTPUT) && ctrl_load && !out_ready) begin
                r_pend_valid <= 1'b1;
                r_pend_pos   <= init_pos;
                r_pend_vel   <= init_vel;
            end
        end
    end

    assign out_pos       = {r_ball.y, r_ball.x};
    assign out_vel       = {r_ball.vy, r_ball.vx};
    assign bounce_count  = r_bounce;
    assign overrun_count = r_overrun;
    assign busy          = w_busy;

endmodule

// File: tb/tb_physics_step_engine.sv
// Self-checking bench for physics_step_engine: a vector table of single steps
// scored through an expectation queue, plus hand-written multi-cycle sequences.
module tb_physics_step_engine;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        ctrl_enable;
    logic        ctrl_load;
    logic [15:0] gravity;
    logic [31:0] init_pos;
    logic [31:0] init_vel;
    logic        frame_tick;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pos;
    logic [31:0] out_vel;
    logic [15:0] bounce_count;
    logic [7:0]  overrun_count;
    logic        busy;

    always #5 clk = ~clk;

    physics_step_engine dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .ctrl_enable     (ctrl_enable),
        .ctrl_load       (ctrl_load),
        .gravity         (gravity),
        .init_pos        (init_pos),
        .init_vel        (init_vel),
        .frame_tick      (frame_tick),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pos         (out_pos),
        .out_vel         (out_vel),
        .bounce_count    (bounce_count),
        .overrun_count   (overrun_count),
        .busy            (busy)
    );

    typedef struct {
        logic [31:0] pos;
        logic [31:0] vel;
        logic [15:0] grav;
        logic [31:0] expPos;
        logic [31:0] expVel;
        logic [15:0] expBounce;
    } vector_t;

    typedef struct {
        logic [31:0] pos;
        logic [31:0] vel;
        logic [15:0] bounce;
    } expect_t;

    expect_t expQ[$];
    vector_t vectors[8];
    int      assertCount = 0;
    int      failCount   = 0;

    function automatic logic [31:0] pk(input int y, input int x);
        return {y[15:0], x[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Optionally loads, then pulses one tick and queues the expected result.
    task automatic applyStimulus(input logic [31:0] pos, input logic [31:0] vel,
                                 input logic [15:0] grav, input bit doLoad,
                                 input logic [31:0] expPos, input logic [31:0] expVel,
                                 input logic [15:0] expBounce);
        expect_t e;
        gravity = grav;
        if (doLoad) begin
            init_pos  = pos;
            init_vel  = vel;
            ctrl_load = 1'b1;
            step();
            ctrl_load = 1'b0;
        end
        e.pos    = expPos;
        e.vel    = expVel;
        e.bounce = expBounce;
        expQ.push_back(e);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int cycles;
        cycles = 1;
        while (!out_valid && cycles < 20) begin
            step();
            cycles++;
        end
        checkOutput({name, " latency"}, 32'(cycles), 32'd3);
    endtask

    task automatic popAndCompare(input string name);
        expect_t e;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s: scoreboard empty, actual pos=%0h expected an entry", name, out_pos);
        end else begin
            e = expQ.pop_front();
            checkOutput({name, " valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, " pos"}, out_pos, e.pos);
            checkOutput({name, " vel"}, out_vel, e.vel);
            checkOutput({name, " bounce"}, 32'(bounce_count), 32'(e.bounce));
        end
    endtask

    task automatic runStep(input string name);
        waitValid(name);
        popAndCompare(name);
        step();
        checkOutput({name, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn     = 1'b0;
        ctrl_enable = 1'b1;
        ctrl_load   = 1'b0;
        gravity     = '0;
        init_pos    = '0;
        init_vel    = '0;
        frame_tick  = 1'b0;
        out_ready   = 1'b1;

        vectors[0] = '{pk(100, 100), pk(0, 3),      16'd1,            pk(100, 103), pk(1, 3),      16'd0};
        vectors[1] = '{pk(200, 630), pk(0, 5),      16'd0,            pk(200, 631), pk(0, -5),     16'd1};
        vectors[2] = '{pk(476, 4),   pk(63, -10),   16'd5,            pk(471, 8),   pk(-64, 10),   16'd2};
        vectors[3] = '{pk(20, 300),  pk(-15, 0),    16'(-60),         pk(8, 300),   pk(64, 0),     16'd1};
        vectors[4] = '{pk(240, 32760), pk(0, 20),   16'd0,            pk(240, 631), pk(0, -20),    16'd1};
        vectors[5] = '{pk(240, 100), pk(0, -32768), 16'd0,            pk(240, 8),   pk(0, 32767),  16'd1};
        vectors[6] = '{pk(469, 630), pk(2, 1),      16'd0,            pk(471, 631), pk(2, 1),      16'd0};
        vectors[7] = '{pk(100, 100), pk(60, 0),     16'd10,           pk(160, 100), pk(64, 0),     16'd0};

        step();
        step();
        checkOutput("reset valid", 32'(out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset pos", out_pos, 32'd0);
        checkOutput("reset vel", out_vel, 32'd0);
        checkOutput("reset bounce", 32'(bounce_count), 32'd0);
        checkOutput("reset overrun", 32'(overrun_count), 32'd0);
        aresetn = 1'b1;
        step();

        // Ticks before the first load must leave the engine idle.
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checkOutput("idle tick busy", 32'(busy), 32'd0);
        checkOutput("idle tick valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].pos, vectors[i].vel, vectors[i].grav, 1'b1,
                          vectors[i].expPos, vectors[i].expVel, vectors[i].expBounce);
            runStep($sformatf("vec%0d", i));
        end

        applyStimulus(pk(200, 630), pk(0, 5), 16'd0, 1'b1, pk(200, 631), pk(0, -5), 16'd1);
        runStep("rwall first");
        applyStimulus('0, '0, 16'd0, 1'b0, pk(200, 626), pk(0, -5), 16'd1);
        runStep("rwall second");

        init_pos  = pk(100, 100);
        init_vel  = pk(0, 0);
        ctrl_load = 1'b1;
        step();
        ctrl_load   = 1'b0;
        ctrl_enable = 1'b0;
        frame_tick  = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checkOutput("disabled busy", 32'(busy), 32'd0);
        checkOutput("disabled overrun", 32'(overrun_count), 32'd0);
        ctrl_enable = 1'b1;

        ctrl_load  = 1'b1;
        frame_tick = 1'b1;
        step();
        ctrl_load  = 1'b0;
        frame_tick = 1'b0;
        step();
        checkOutput("load+tick busy", 32'(busy), 32'd0);
        checkOutput("load+tick overrun", 32'(overrun_count), 32'd0);

        // Backpressure: result must hold while two ticks are dropped.
        out_ready = 1'b0;
        applyStimulus(pk(100, 100), pk(0, 3), 16'd1, 1'b1, pk(100, 103), pk(1, 3), 16'd0);
        waitValid("bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 2 || i == 5) frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            checkOutput($sformatf("bp hold valid %0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp hold pos %0d", i), out_pos, pk(100, 103));
        end
        checkOutput("bp overrun", 32'(overrun_count), 32'd2);
        out_ready = 1'b1;
        popAndCompare("bp");
        step();
        checkOutput("bp valid drop", 32'(out_valid), 32'd0);
        checkOutput("bp overrun kept", 32'(overrun_count), 32'd2);

        // Two loads while stalled in OUTPUT: the later one is applied after delivery.
        out_ready = 1'b0;
        applyStimulus(pk(200, 630), pk(0, 5), 16'd0, 1'b1, pk(200, 631), pk(0, -5), 16'd1);
        waitValid("ldout");
        init_pos  = pk(300, 300);
        init_vel  = pk(0, 7);
        ctrl_load = 1'b1;
        step();
        init_pos = pk(50, 50);
        init_vel = pk(0, 2);
        step();
        ctrl_load = 1'b0;
        checkOutput("ldout still valid", 32'(out_valid), 32'd1);
        checkOutput("ldout pos held", out_pos, pk(200, 631));
        checkOutput("ldout bounce held", 32'(bounce_count), 32'd1);
        out_ready = 1'b1;
        popAndCompare("ldout");
        step();
        checkOutput("ldout valid drop", 32'(out_valid), 32'd0);
        checkOutput("ldout busy", 32'(busy), 32'd0);
        checkOutput("ldout new pos", out_pos, pk(50, 50));
        checkOutput("ldout new vel", out_vel, pk(0, 2));
        checkOutput("ldout bounce cleared", 32'(bounce_count), 32'd0);
        applyStimulus('0, '0, 16'd0, 1'b0, pk(50, 52), pk(0, 2), 16'd0);
        runStep("ldout next");

        // Reset while the step is in COLLIDE.
        init_pos  = pk(100, 100);
        init_vel  = pk(0, 3);
        gravity   = 16'd1;
        ctrl_load = 1'b1;
        step();
        ctrl_load  = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        checkOutput("midreset busy before", 32'(busy), 32'd1);
        aresetn = 1'b0;
        step();
        checkOutput("midreset valid", 32'(out_valid), 32'd0);
        checkOutput("midreset busy", 32'(busy), 32'd0);
        checkOutput("midreset pos", out_pos, 32'd0);
        checkOutput("midreset vel", out_vel, 32'd0);
        checkOutput("midreset bounce", 32'(bounce_count), 32'd0);
        checkOutput("midreset overrun", 32'(overrun_count), 32'd0);
        aresetn    = 1'b1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("post reset busy %0d", i), 32'(busy), 32'd0);
            checkOutput($sformatf("post reset valid %0d", i), 32'(out_valid), 32'd0);
        end
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
